// File: rtl/mnist_frame_driver_if.sv
// Shared pixel/score type for the mnist pipeline, and the bundle of host,
// feature-stream and prediction-stream signals around mnist_frame_driver.
package mnist_pkg;
    typedef logic signed [15:0] feature_type;
endpackage

interface mnist_frame_driver_if #(
    parameter int ADDR_W = 10
);
    logic                    pixel_wr_en;
    logic [ADDR_W-1:0]       pixel_wr_addr;
    mnist_pkg::feature_type  pixel_wr_data;
    logic                    start;
    logic                    busy;
    mnist_pkg::feature_type  feature_out;
    logic                    feature_out_valid;
    logic                    feature_out_ready;
    mnist_pkg::feature_type  prediction_in;
    logic                    prediction_in_valid;
    logic                    prediction_in_ready;
    logic                    done;
    logic [3:0]              class_out;
    mnist_pkg::feature_type  class_score;

    // master: the frame driver itself
    modport master (
        input  pixel_wr_en, pixel_wr_addr, pixel_wr_data, start,
               feature_out_ready, prediction_in, prediction_in_valid,
        output busy, feature_out, feature_out_valid, prediction_in_ready,
               done, class_out, class_score
    );

    // slave: the host plus the network on the other side of the streams
    modport slave (
        output pixel_wr_en, pixel_wr_addr, pixel_wr_data, start,
               feature_out_ready, prediction_in, prediction_in_valid,
        input  busy, feature_out, feature_out_valid, prediction_in_ready,
               done, class_out, class_score
    );
endinterface

// File: rtl/mnist_frame_driver.sv
// Buffers one image from the host, streams it to the network, then collects
// the class scores and reports the arg-max class with its score.
module mnist_frame_driver
    import mnist_pkg::*;
#(
    parameter int IMAGE_PIXELS = 784,
    parameter int NUM_CLASSES  = 10,
    parameter int ADDR_W       = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    mnist_frame_driver_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   PIX_LIMIT  = (ADDR_W+1)'(IMAGE_PIXELS);
    localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(IMAGE_PIXELS - 1);
    localparam logic [ADDR_W-1:0] PIX_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PIX_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        CLS_LAST   = 4'(NUM_CLASSES - 1);
    localparam feature_type       SCORE_ZERO = feature_type'(1'b0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [3:0]        cls_cnt_q, cls_cnt_d;
    logic [3:0]        best_idx_q, best_idx_d;
    feature_type       best_score_q, best_score_d;
    logic [3:0]        class_out_q, class_out_d;
    feature_type       class_score_q, class_score_d;

    feature_type       pix_buf [IMAGE_PIXELS];

    logic pix_xfer_s;
    logic pix_last_s;
    logic pred_xfer_s;
    logic cls_last_s;
    logic take_s;
    logic wr_ok_s;

    assign pix_xfer_s  = (state_q == S_STREAM) && bus.feature_out_ready;
    assign pix_last_s  = (pix_cnt_q == PIX_LAST);
    assign pred_xfer_s = (state_q == S_COLLECT) && bus.prediction_in_valid;
    assign cls_last_s  = (cls_cnt_q == CLS_LAST);
    // Strict signed greater-than: a tie never displaces the lower index.
    assign take_s      = (cls_cnt_q == 4'd0) || (bus.prediction_in > best_score_q);
    assign wr_ok_s     = bus.pixel_wr_en && (state_q == S_IDLE)
                         && ({1'b0, bus.pixel_wr_addr} < PIX_LIMIT);

    // The image buffer is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            pix_buf[bus.pixel_wr_addr] <= bus.pixel_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (pix_xfer_s && pix_last_s) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_COLLECT: begin
                if (pred_xfer_s && cls_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy                = 1'b1;
        bus.feature_out_valid   = 1'b0;
        bus.prediction_in_ready = 1'b0;
        bus.done                = 1'b0;
        case (state_q)
            S_IDLE:    bus.busy                = 1'b0;
            S_STREAM:  bus.feature_out_valid   = 1'b1;
            S_COLLECT: bus.prediction_in_ready = 1'b1;
            S_DONE:    bus.done                = 1'b1;
            default:   bus.busy                = 1'b0;
        endcase
    end

    assign bus.feature_out = pix_buf[pix_cnt_q];
    assign bus.class_out   = class_out_q;
    assign bus.class_score = class_score_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_cnt_q     <= PIX_ZERO;
            cls_cnt_q     <= 4'd0;
            best_idx_q    <= 4'd0;
            best_score_q  <= SCORE_ZERO;
            class_out_q   <= 4'd0;
            class_score_q <= SCORE_ZERO;
        end else begin
            pix_cnt_q     <= pix_cnt_d;
            cls_cnt_q     <= cls_cnt_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            class_out_q   <= class_out_d;
            class_score_q <= class_score_d;
        end
    end

    // The result registers load on the last score's edge so done and the
    // new class appear together in the DONE cycle.
    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        cls_cnt_d     = cls_cnt_q;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        class_out_d   = class_out_q;
        class_score_d = class_score_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pix_cnt_d = PIX_ZERO;
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
            end
            S_STREAM: begin
                if (pix_xfer_s && pix_last_s) begin
                    pix_cnt_d    = PIX_ZERO;
                    cls_cnt_d    = 4'd0;
                    best_idx_d   = 4'd0;
                    best_score_d = SCORE_ZERO;
                end else if (pix_xfer_s) begin
                    pix_cnt_d = pix_cnt_q + PIX_ONE;
                end else begin
                    pix_cnt_d = pix_cnt_q;
                end
            end
            S_COLLECT: begin
                if (pred_xfer_s) begin
                    if (take_s) begin
                        best_idx_d   = cls_cnt_q;
                        best_score_d = bus.prediction_in;
                    end else begin
                        best_idx_d   = best_idx_q;
                        best_score_d = best_score_q;
                    end
                    cls_cnt_d = cls_cnt_q + 4'd1;
                    if (cls_last_s) begin
                        class_out_d   = best_idx_d;
                        class_score_d = best_score_d;
                    end else begin
                        class_out_d   = class_out_q;
                        class_score_d = class_score_q;
                    end
                end else begin
                    cls_cnt_d = cls_cnt_q;
                end
            end
            S_DONE:  cls_cnt_d = cls_cnt_q;
            default: cls_cnt_d = cls_cnt_q;
        endcase
    end

endmodule
